// File: rtl/regfile_wb_if.sv
// Write-back bus between the two result sources (ALU, load unit) and the register-file write port.
interface regfile_wb_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
);
  localparam int unsigned PPP_W = 3;
  localparam int unsigned CNT_W = 8;

  // Source A (ALU)
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic [PPP_W-1:0]  a_ppp;
  logic              a_ready;

  // Source B (load unit)
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic [PPP_W-1:0]  b_ppp;
  logic              b_ready;

  logic              wb_stall;

  // Register-file write port and status
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [PPP_W-1:0]  wr_ppp;
  logic              err_ppp;
  logic              last_grant;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output a_valid, a_addr, a_data, a_ppp,
    output b_valid, b_addr, b_data, b_ppp,
    output wb_stall,
    input  a_ready, b_ready,
    input  wr_en, wr_addr, wr_data, wr_ppp, err_ppp, last_grant, drop_cnt
  );

  modport slave (
    input  a_valid, a_addr, a_data, a_ppp,
    input  b_valid, b_addr, b_data, b_ppp,
    input  wb_stall,
    output a_ready, b_ready,
    output wr_en, wr_addr, wr_data, wr_ppp, err_ppp, last_grant, drop_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging ALU and load-unit write-backs into one registered
// register-file write port; drops writes to r0 and writes with illegal ppp codes.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
) (
  input logic         clk,
  input logic         reset,
  regfile_wb_if.slave bus
);
  localparam int unsigned PPP_W = 3;
  localparam int unsigned CNT_W = 8;
  localparam logic [PPP_W-1:0] PPP_MAX_LEGAL = PPP_W'(4);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [PPP_W-1:0]  ppp;
  } wb_req_t;

  wb_req_t req_a;
  wb_req_t req_b;
  wb_req_t sel;
  logic    grant_a;
  logic    grant_b;
  logic    handshake;
  logic    ppp_legal;
  logic    addr_zero;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [PPP_W-1:0]  wr_ppp_q;
  logic              err_ppp_q;
  logic              last_grant_q;
  logic [CNT_W-1:0]  drop_cnt_q;

  always_comb begin
    req_a = '{addr: bus.a_addr, data: bus.a_data, ppp: bus.a_ppp};
    req_b = '{addr: bus.b_addr, data: bus.b_data, ppp: bus.b_ppp};
  end

  // last_grant_q=1 means B went last, so A has priority on contention.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && !bus.wb_stall) begin
      if (bus.a_valid && (!bus.b_valid || last_grant_q)) begin
        grant_a = 1'b1;
      end else if (bus.b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  always_comb begin
    handshake = grant_a | grant_b;
    sel       = grant_b ? req_b : req_a;
    ppp_legal = (sel.ppp <= PPP_MAX_LEGAL);
    addr_zero = (sel.addr == '0);
  end

  // Output register; dropped requests leave the data fields untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_ppp_q     <= '0;
      err_ppp_q    <= 1'b0;
      last_grant_q <= 1'b1;
      drop_cnt_q   <= '0;
    end else begin
      wr_en_q   <= 1'b0;
      err_ppp_q <= 1'b0;
      if (handshake) begin
        last_grant_q <= grant_b;
        if (!ppp_legal || addr_zero) begin
          err_ppp_q <= ~ppp_legal;
          if (drop_cnt_q != '1) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
          end
        end else begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= sel.addr;
          wr_data_q <= sel.data;
          wr_ppp_q  <= sel.ppp;
        end
      end
    end
  end

  assign bus.a_ready    = grant_a;
  assign bus.b_ready    = grant_b;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_ppp     = wr_ppp_q;
  assign bus.err_ppp    = err_ppp_q;
  assign bus.last_grant = last_grant_q;
  assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: the driver queues expected write-port
// events, a monitor pops and compares them whenever wr_en or err_ppp is seen.
module tb_regfile_wb_arbiter;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_WR   = 2'b10;
  localparam logic [1:0] K_ERR  = 2'b01;

  typedef struct packed {
    logic [1:0]        kind;
    logic [31:0]       cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [2:0]        ppp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cyc = 32'd0;
  exp_t        sb[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  regfile_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic [2:0] ap, input logic bv, input logic [ADDR_W-1:0] ba,
                       input logic [DATA_W-1:0] bd, input logic [2:0] bp, input logic st);
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad; bus.a_ppp = ap;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd; bus.b_ppp = bp;
    bus.wb_stall = st;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 3'b000, 1'b0, '0, '0, 3'b000, 1'b0);
  endtask

  // g: 0 no grant, 1 A granted, 2 B granted; kind: write-port event expected next cycle.
  task automatic tick(input int g, input logic [1:0] kind);
    exp_t e;
    @(negedge clk);
    check("a_ready", {63'd0, bus.a_ready}, {63'd0, g == 1});
    check("b_ready", {63'd0, bus.b_ready}, {63'd0, g == 2});
    if (kind != K_NONE) begin
      e.kind = kind;
      e.cyc  = cyc + 32'd1;
      e.addr = (g == 2) ? bus.b_addr : bus.a_addr;
      e.data = (g == 2) ? bus.b_data : bus.a_data;
      e.ppp  = (g == 2) ? bus.b_ppp  : bus.a_ppp;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
    check("rst_wr_addr", {59'd0, bus.wr_addr}, 64'd0);
    check("rst_wr_data", bus.wr_data, 64'd0);
    check("rst_wr_ppp", {61'd0, bus.wr_ppp}, 64'd0);
    check("rst_err_ppp", {63'd0, bus.err_ppp}, 64'd0);
    check("rst_last_grant", {63'd0, bus.last_grant}, 64'd1);
    check("rst_drop_cnt", {56'd0, bus.drop_cnt}, 64'd0);
  endtask

  // Monitor: every wr_en or err_ppp pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.wr_en === 1'b1 || bus.err_ppp === 1'b1) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: wr_en=%b err_ppp=%b at cycle %0d, expected none",
                   bus.wr_en, bus.err_ppp, cyc);
        end else begin
          e = sb.pop_front();
          check("out_kind", {62'd0, bus.wr_en, bus.err_ppp}, {62'd0, e.kind});
          check("out_cycle", {32'd0, cyc}, {32'd0, e.cyc});
          if (e.kind == K_WR) begin
            check("wr_addr", {59'd0, bus.wr_addr}, {59'd0, e.addr});
            check("wr_data", bus.wr_data, e.data);
            check("wr_ppp", {61'd0, bus.wr_ppp}, {61'd0, e.ppp});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    // Requests present during reset are not consumed.
    reset = 1'b1;
    drive(1'b1, 5'd4, 64'hDEAD, 3'b000, 1'b1, 5'd6, 64'hBEEF, 3'b000, 1'b0);
    tick(0, K_NONE);
    tick(0, K_NONE);
    check_reset_vals();
    reset = 1'b0;

    // Single A request.
    drive(1'b1, 5'd5, 64'h1122334455667788, 3'b000, 1'b0, '0, '0, 3'b000, 1'b0);
    tick(1, K_WR);
    idle();
    tick(0, K_NONE);
    check("last_grant_after_a", {63'd0, bus.last_grant}, 64'd0);
    check("hold_wr_addr", {59'd0, bus.wr_addr}, 64'd5);
    check("hold_wr_data", bus.wr_data, 64'h1122334455667788);

    // Contention right after reset, both sources target the same register.
    reset = 1'b1;
    tick(0, K_NONE);
    reset = 1'b0;
    drive(1'b1, 5'd7, 64'hAAAA_0000_0000_0001, 3'b000, 1'b1, 5'd7, 64'hBBBB_0000_0000_0002, 3'b010, 1'b0);
    tick(1, K_WR);
    tick(2, K_WR);
    tick(1, K_WR);
    tick(2, K_WR);
    idle();
    tick(0, K_NONE);
    check("last_grant_after_contention", {63'd0, bus.last_grant}, 64'd1);
    check("hold_after_contention", bus.wr_data, 64'hBBBB_0000_0000_0002);

    // Illegal ppp from B.
    drive(1'b0, '0, '0, 3'b000, 1'b1, 5'd3, 64'h33, 3'b101, 1'b0);
    tick(2, K_ERR);
    idle();
    tick(0, K_NONE);
    check("drop_cnt_illegal", {56'd0, bus.drop_cnt}, 64'd1);
    check("err_ppp_one_cycle", {63'd0, bus.err_ppp}, 64'd0);
    check("hold_after_drop", {59'd0, bus.wr_addr}, 64'd7);

    // Write to r0 is dropped silently.
    drive(1'b1, 5'd0, 64'h44, 3'b000, 1'b0, '0, '0, 3'b000, 1'b0);
    tick(1, K_NONE);
    idle();
    tick(0, K_NONE);
    check("drop_cnt_zero_addr", {56'd0, bus.drop_cnt}, 64'd2);
    check("last_grant_after_drop", {63'd0, bus.last_grant}, 64'd0);

    // Illegal ppp to r0 still flags the error.
    drive(1'b1, 5'd0, 64'h55, 3'b111, 1'b0, '0, '0, 3'b000, 1'b0);
    tick(1, K_ERR);
    idle();
    tick(0, K_NONE);
    check("drop_cnt_illegal_zero", {56'd0, bus.drop_cnt}, 64'd3);

    // Stall for 3 cycles, then B resumes first since A went last.
    drive(1'b1, 5'd10, 64'hA10, 3'b001, 1'b1, 5'd11, 64'hB11, 3'b100, 1'b1);
    tick(0, K_NONE);
    tick(0, K_NONE);
    tick(0, K_NONE);
    bus.wb_stall = 1'b0;
    tick(2, K_WR);
    tick(1, K_WR);
    drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 1'b0, '0, '0, 3'b000, 1'b0);
    tick(1, K_WR);

    // Saturate the drop counter.
    drive(1'b1, 5'd0, 64'h0, 3'b000, 1'b0, '0, '0, 3'b000, 1'b0);
    for (int i = 0; i < 300; i++) tick(1, K_NONE);
    idle();
    tick(0, K_NONE);
    check("drop_cnt_saturated", {56'd0, bus.drop_cnt}, 64'd255);

    // Reset while a write sits in the output register.
    drive(1'b1, 5'd12, 64'hC0FFEE, 3'b010, 1'b0, '0, '0, 3'b000, 1'b0);
    tick(1, K_WR);
    reset = 1'b1;
    bus.b_valid = 1'b1;
    tick(0, K_NONE);
    check_reset_vals();
    reset = 1'b0;
    idle();
    tick(0, K_NONE);
    tick(0, K_NONE);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
